// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide
// behind a valid/ready handshake, with single-cycle handling of b==0 and signed overflow.
module muldiv_sequencer #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            is_m,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int MUL_N = XLEN / MUL_STEP;
    localparam int CW    = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]        r_op;
    logic              r_neg;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_result;

    logic              w_idle;
    logic              w_accept;
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_result;
    logic [CW-1:0]     w_cnt_init;
    logic              w_last_step;

    assign is_m      = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
    assign w_idle    = (r_state == S_IDLE);
    assign in_ready  = w_idle;
    assign busy      = !w_idle;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign w_accept  = in_valid && w_idle && is_m && !kill;

    // Operand decode: signedness per op, magnitudes and the sign the result must carry
    assign w_is_div   = Funct3[2];
    assign w_a_signed = Funct3[2] ? !Funct3[0] : (Funct3[1:0] == 2'b01 || Funct3[1:0] == 2'b10);
    assign w_b_signed = Funct3[2] ? !Funct3[0] : (Funct3[1:0] == 2'b01);
    assign w_a_neg    = w_a_signed && op_a[XLEN-1];
    assign w_b_neg    = w_b_signed && op_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -op_a : op_a;
    assign w_b_mag    = w_b_neg ? -op_b : op_b;
    assign w_neg      = (w_is_div && Funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_b_zero = (op_b == {XLEN{1'b0}});
    assign w_ovf    = w_is_div && !Funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    assign w_fast   = w_is_div && (w_b_zero || w_ovf);
    always_comb begin
        w_fast_result = op_a;
        if (Funct3[1]) begin
            w_fast_result = w_b_zero ? op_a : {XLEN{1'b0}};
        end else if (w_b_zero) begin
            w_fast_result = {XLEN{1'b1}};
        end
    end

    assign w_cnt_init  = w_is_div ? CW'(XLEN) : CW'(MUL_N);
    assign w_last_step = (r_cnt == CW'(1));

    // Multiply: low half of r_acc holds the remaining multiplier bits, high half the partial sum
    logic [2*XLEN-1:0] w_mul_next;
    for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_mul_stage
        logic [2*XLEN-1:0] w_in;
        logic [XLEN:0]     w_sum;
        logic [2*XLEN-1:0] w_out;
        if (gi == 0) begin : g_first
            assign w_in = r_acc;
        end else begin : g_chain
            assign w_in = g_mul_stage[gi-1].w_out;
        end
        assign w_sum = {1'b0, w_in[2*XLEN-1:XLEN]} + {1'b0, (w_in[0] ? r_mcand : {XLEN{1'b0}})};
        assign w_out = {w_sum, w_in[XLEN-1:1]};
    end
    assign w_mul_next = g_mul_stage[MUL_STEP-1].w_out;

    // Restoring divide: the trial remainder carries one guard bit above XLEN
    logic [XLEN:0]   w_trial;
    logic            w_qbit;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    assign w_trial    = {r_rem, r_quo[XLEN-1]};
    assign w_qbit     = (w_trial >= {1'b0, r_mcand});
    assign w_diff     = w_trial[XLEN-1:0] - r_mcand;
    assign w_rem_next = w_qbit ? w_diff : w_trial[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], w_qbit};

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_div_raw;
    logic [XLEN-1:0]   w_div_res;
    logic [XLEN-1:0]   w_calc_result;
    assign w_prod        = r_neg ? -w_mul_next : w_mul_next;
    assign w_mul_res     = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    assign w_div_raw     = r_op[1] ? w_rem_next : w_quo_next;
    assign w_div_res     = r_neg ? -w_div_raw : w_div_raw;
    assign w_calc_result = r_op[2] ? w_div_res : w_mul_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_fast ? S_DONE : S_CALC;
            S_CALC: if (w_last_step) w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (kill) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 3'b000;
            r_neg    <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_mcand  <= {XLEN{1'b0}};
            r_rem    <= {XLEN{1'b0}};
            r_quo    <= {XLEN{1'b0}};
            r_result <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_op    <= Funct3;
            r_neg   <= w_neg;
            r_cnt   <= w_cnt_init;
            r_acc   <= {{XLEN{1'b0}}, w_b_mag};
            r_mcand <= w_is_div ? w_b_mag : w_a_mag;
            r_rem   <= {XLEN{1'b0}};
            r_quo   <= w_a_mag;
            if (w_fast) begin
                r_result <= w_fast_result;
            end
        end else if (r_state == S_CALC && !kill) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_op[2]) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
            end else begin
                r_acc <= w_mul_next;
            end
            if (w_last_step) begin
                r_result <= w_calc_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, handshake/flush/reset sequences,
// and random operations against an arithmetic reference model (MUL_STEP 1 and 4 instances).
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        in_valid0, in_valid1;
    logic        out_ready0, out_ready1;
    logic        in_ready0, in_ready1;
    logic        is_m0, is_m1;
    logic        busy0, busy1;
    logic        out_valid0, out_valid1;
    logic [31:0] result0, result1;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.XLEN(32), .MUL_STEP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .in_valid(in_valid0), .in_ready(in_ready0), .op_a(op_a), .op_b(op_b),
        .kill(kill), .is_m(is_m0), .busy(busy0), .out_valid(out_valid0),
        .out_ready(out_ready0), .result(result0)
    );

    muldiv_sequencer #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .in_valid(in_valid1), .in_ready(in_ready1), .op_a(op_a), .op_b(op_b),
        .kill(kill), .is_m(is_m1), .busy(busy1), .out_valid(out_valid1),
        .out_ready(out_ready1), .result(result1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          which;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_ov(input int which);
        return (which == 0) ? out_valid0 : out_valid1;
    endfunction

    function automatic logic get_ir(input int which);
        return (which == 0) ? in_ready0 : in_ready1;
    endfunction

    function automatic logic [31:0] get_res(input int which);
        return (which == 0) ? result0 : result1;
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input int which, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        int step;
        step = (which == 0) ? 1 : 4;
        if (f3[2]) begin
            if (b == 0) return 1;
            if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return 33;
        end
        return 32 / step + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_op(input int which, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        ALUOp  = 2'b10;
        Funct7 = 7'b0000001;
        Funct3 = f3;
        op_a   = a;
        op_b   = b;
        if (which == 0) in_valid0 = 1'b1;
        else            in_valid1 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic run_op(input int which, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold, input string tag);
        int lat;
        drive_op(which, f3, a, b);
        lat = 1;
        while (!get_ov(which) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        $display("%s dut%0d f3=%0d a=%h b=%h result=%h latency=%0d", tag, which, f3, a, b,
                 get_res(which), lat);
        chk({tag, "_result"}, get_res(which), exp);
        chk({tag, "_latency"}, lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_result"}, get_res(which), exp);
            chk({tag, "_hold_valid"}, get_ov(which), 1);
            chk({tag, "_hold_in_ready"}, get_ir(which), 0);
        end
        if (which == 0) out_ready0 = 1'b1;
        else            out_ready1 = 1'b1;
        @(negedge clk);
        out_ready0 = 1'b0;
        out_ready1 = 1'b0;
        chk({tag, "_released"}, {get_ov(which), get_ir(which)}, 2'b01);
    endtask

    initial begin
        int          seen;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          w;

        rst_n = 1'b0; kill = 1'b0;
        ALUOp = 2'b00; Funct7 = 7'b0; Funct3 = 3'b0; op_a = 32'h0; op_b = 32'h0;
        in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready0 = 1'b0; out_ready1 = 1'b0;

        vecs[0]  = '{0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 5};
        vecs[1]  = '{0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0};
        vecs[2]  = '{0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0};
        vecs[3]  = '{0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0};
        vecs[4]  = '{0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0};
        vecs[5]  = '{0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0};
        vecs[6]  = '{0, 3'd5, 32'hFFFFFFFE, 32'd3,        32'h55555554, 33, 0};
        vecs[7]  = '{0, 3'd7, 32'hFFFFFFFE, 32'd3,        32'd2,        33, 0};
        vecs[8]  = '{0, 3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  2};
        vecs[9]  = '{0, 3'd6, 32'd5,        32'd0,        32'd5,        1,  0};
        vecs[10] = '{0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0};
        vecs[11] = '{0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0};
        vecs[12] = '{0, 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33, 0};
        vecs[13] = '{0, 3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0};
        vecs[14] = '{1, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 9,  3};
        vecs[15] = '{1, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 9,  0};
        vecs[16] = '{1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 9,  0};
        vecs[17] = '{1, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0};

        // Reset state, both during and after reset
        #2;
        chk("reset_outputs", {in_ready0, busy0, out_valid0, result0}, {1'b1, 1'b0, 1'b0, 32'h0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {in_ready0, busy0, out_valid0, result0}, {1'b1, 1'b0, 1'b0, 32'h0});
        chk("post_reset_dut4", {in_ready1, busy1, out_valid1, result1}, {1'b1, 1'b0, 1'b0, 32'h0});

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].which, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                   vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Non-M instruction with in_valid high must be ignored
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'd0; in_valid0 = 1'b1;
        #1 chk("not_m_is_m", is_m0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("not_m_busy", {busy0, in_ready0}, 2'b01);
        end
        in_valid0 = 1'b0;
        ALUOp = 2'b00; Funct7 = 7'b0000001;
        #1 chk("aluop00_is_m", is_m0, 0);
        ALUOp = 2'b10;
        #1 chk("m_is_m", is_m0, 1);

        // Kill during CALC: back to IDLE, no result, result register untouched
        drive_op(0, 3'd4, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        chk("kill_pre_busy", busy0, 1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_idle", {busy0, in_ready0, out_valid0}, 3'b010);
        chk("kill_result_kept", result0, 32'h80000000);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid0) seen++;
        end
        chk("kill_no_out_valid", seen, 0);

        // Kill together with out_ready in DONE
        drive_op(0, 3'd4, 32'd5, 32'd0);
        chk("fast_done", out_valid0, 1);
        kill = 1'b1; out_ready0 = 1'b1;
        @(negedge clk);
        kill = 1'b0; out_ready0 = 1'b0;
        chk("kill_done_idle", {out_valid0, in_ready0}, 2'b01);
        chk("kill_done_result", result0, 32'hFFFFFFFF);

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            w  = i % 2;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(w, f3, a, b, ref_model(f3, a, b), ref_lat(w, f3, a, b),
                   int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of CALC
        run_op(0, 3'd7, 32'd17, 32'd5, 32'd2, 33, 0, "pre_rst");
        drive_op(0, 3'd0, 32'd7, 32'hFFFFFFFD);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outputs", {out_valid0, busy0, in_ready0, result0},
               {1'b0, 1'b0, 1'b1, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle RV32M execution unit for the RISC-V core. It decodes `ALUOp`/`Funct7`/`Funct3` for the M extension and runs an iterative shift-add multiply or a restoring divide over `XLEN`-parametrised operands. It sits beside the single-cycle ALU in EX and stalls the pipeline through a valid/ready handshake. Divide-by-zero and signed overflow take a fast path.

## Interface
- `XLEN`, 32: operand/result width; must be ≥ 8 and a power of two.
- `MUL_STEP`, 1: multiplier bits retired per cycle; one of 1, 2, 4; must divide `XLEN`.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ALUOp`  in  2  controller opcode; the M extension requires `2'b10`.
- `Funct7`  in  7  instruction bits 31:25; the M extension requires `7'b0000001`.
- `Funct3`  in  3  instruction bits 14:12; selects the op.
- `in_valid`  in  1  operands and decode fields are valid.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `op_a`  in  XLEN  rs1 value.
- `op_b`  in  XLEN  rs2 value.
- `kill`  in  1  synchronous flush from the hazard unit.
- `is_m`  out  1  combinational: `ALUOp==2'b10 && Funct7==7'b0000001`.
- `busy`  out  1  state ≠ IDLE.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  XLEN  result; stable while `out_valid` is high.

## Operation
- Funct3 encoding: 000 MUL (low half), 001 MULH (s×s high), 010 MULHSU (signed a × unsigned b, high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Accept condition: `in_valid && in_ready && is_m && !kill`. When `is_m` is 0, `in_valid` is ignored.
- On accept:
  - Latch the op.
  - Convert signed operands to magnitudes; record the result sign.
  - Multiply sign = sign(a) XOR sign(b), for signed operands only.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- States:
  - IDLE: accept → CALC with step counter = `XLEN/MUL_STEP` (multiply) or `XLEN` (divide). A fast-path case goes → DONE instead.
  - CALC: one step per cycle; counter decrements. After the final step, apply sign correction, register `result` → DONE.
  - DONE: `out_valid=1`. `out_ready` → IDLE.
  - `kill` in any state → IDLE next edge. `out_valid` drops, `result` is unchanged, and no result is delivered.
- Multiply: 2·XLEN-bit product accumulator. Each step adds `MUL_STEP` partial products of the multiplicand magnitude. The final product is negated in 2·XLEN bits if negative. MUL selects bits [XLEN-1:0]; the high variants select [2XLEN-1:XLEN].
- Divide: restoring, one quotient bit per step, XLEN-bit remainder plus one guard bit.
- Fast paths (result registered at accept; DONE next cycle):
  - b==0: quotient = all ones (DIV, DIVU); remainder = a (REM, REMU).
  - DIV/REM with a = most-negative and b = −1: quotient = a; remainder = 0.
- Reset: state IDLE, `out_valid`=0, `result`=0, counters/accumulators 0, so `in_ready`=1 and `busy`=0.

## Timing
- Accept at edge k. CALC occupies cycles k+1..k+N. `out_valid` rises at k+N+1.
  - N = `XLEN/MUL_STEP` for MUL* (32 when `XLEN`=32, `MUL_STEP`=1; 8 when `MUL_STEP`=4).
  - N = `XLEN` for DIV*.
- Fast path: `out_valid` at k+1.
- Handshake completes on the edge where `out_valid && out_ready`. `in_ready` returns in the following cycle. There is no overlap between a result and a new accept; minimum issue interval is N+2 cycles.
- `out_ready` low in DONE: `out_valid` and `result` hold indefinitely.
- `kill` and `out_ready` in the same DONE cycle: kill wins (→ IDLE; the consumer discards).
- `rst_n` low mid-operation: outputs take reset values immediately (asynchronous). Resumption starts in IDLE.

## Test plan
- MUL 7 × 0xFFFFFFFD: result 0xFFFFFFEB; `out_valid` exactly 33 cycles after accept (`MUL_STEP`=1); 9 cycles with `MUL_STEP`=4.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFE/3 → 0x55555554; REMU → 2. Each with `out_valid` 33 cycles after accept.
- Fast paths:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - `out_valid` 1 cycle after accept.
- Backpressure and flush:
  - Hold `out_ready`=0 for 5 cycles: `result` stable, `in_ready`=0.
  - Assert `kill` at CALC cycle 10: IDLE next cycle and no `out_valid`.
  - Assert `rst_n`=0 mid-CALC: `out_valid`=0 and `result`=0 immediately.
- `in_valid`=1 with `Funct7`=0000000, `ALUOp`=10: `is_m`=0, nothing accepted, `busy` stays 0.
